// File: rtl/cdrtrig_pkg.sv
// Shared types and constants for the 8b/10b CDR trigger matcher.
//   trig_mode_t  : cfg_mode encodings (value 3 is reserved and never fires)
//   trig_state_t : arm/holdoff/single-shot FSM states
//   MAX_PATTERN_LEN, FILL_W : pattern length limit and history-fill counter width
package cdrtrig_pkg;

   localparam int unsigned MAX_PATTERN_LEN = 16;
   // Holds 0..MAX_PATTERN_LEN-1; the +LANES sum is formed one bit wider.
   localparam int unsigned FILL_W = $clog2(MAX_PATTERN_LEN) + 1;

   typedef enum logic [1:0] {
      TRIG_8B10B_PATTERN = 2'd0,
      TRIG_8B10B_DISPERR = 2'd1,
      TRIG_8B10B_SYMERR  = 2'd2
   } trig_mode_t;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      HOLDOFF  = 2'd2
   } trig_state_t;

endpackage

// File: rtl/pattern_match_window_8b10b.sv
// Compares one PATTERN_LEN-symbol window (symbol 0 earliest, at [7:0]) against the
// programmed pattern.
//   win_data/win_ctl   : window bytes and K-flags
//   cfg_data/cfg_type  : expected bytes and K-flags
//   cfg_mask           : 1 = symbol checked, 0 = don't care
//   match              : every checked symbol matches byte and K-flag
module pattern_match_window_8b10b
   import cdrtrig_pkg::*;
#(
   parameter int unsigned PATTERN_LEN = 10
) (
   input  logic [PATTERN_LEN*8-1:0] win_data,
   input  logic [PATTERN_LEN-1:0]   win_ctl,
   input  logic [PATTERN_LEN*8-1:0] cfg_data,
   input  logic [PATTERN_LEN-1:0]   cfg_type,
   input  logic [PATTERN_LEN-1:0]   cfg_mask,
   output logic                     match
);

   always_comb begin
      match = 1'b1;
      for (int i = 0; i < PATTERN_LEN; i++) begin
         if (cfg_mask[i] && ((win_data[8*i +: 8] != cfg_data[8*i +: 8]) ||
                             (win_ctl[i] != cfg_type[i]))) begin
            match = 1'b0;
         end
      end
   end

endmodule

// File: rtl/cdr_trigger_8b10b_matcher.sv
// 8b/10b pattern / error trigger for the CDR trigger path (rx_clk domain).
// Inputs : sym_valid, sym_data, sym_is_ctl, sym_disp_err, sym_symbol_err (per lane;
//          lane LANES-1 earliest, lane 0 latest), lock_in, cfg_* from the register file,
//          arm / disarm / match_count_clr pulses.
// Outputs: trig_out (one-cycle pulse, 2 clk after the word completing a hit), match_lane,
//          armed, match_count.
// Build option: CDR_TRIG_MATCH_COUNTER_EN builds the saturating match counter; otherwise
// match_count is tied to 0.
module cdr_trigger_8b10b_matcher
   import cdrtrig_pkg::*;
#(
   parameter  int unsigned LANES         = 4,
   parameter  int unsigned PATTERN_LEN   = 10,
   parameter  int unsigned HOLDOFF_WIDTH = 16,
   localparam int unsigned LANE_W        = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sym_valid,
   input  logic [LANES*8-1:0]         sym_data,
   input  logic [LANES-1:0]           sym_is_ctl,
   input  logic [LANES-1:0]           sym_disp_err,
   input  logic [LANES-1:0]           sym_symbol_err,
   input  logic                       lock_in,
   input  logic [1:0]                 cfg_mode,
   input  logic [PATTERN_LEN*8-1:0]   cfg_data,
   input  logic [PATTERN_LEN-1:0]     cfg_type,
   input  logic [PATTERN_LEN-1:0]     cfg_mask,
   input  logic                       cfg_single,
   input  logic [HOLDOFF_WIDTH-1:0]   cfg_holdoff,
   input  logic                       arm,
   input  logic                       disarm,
   input  logic                       match_count_clr,
   output logic                       trig_out,
   output logic [LANE_W-1:0]          match_lane,
   output logic                       armed,
   output logic [31:0]                match_count
);

   // One storage slot is kept even for PATTERN_LEN=1 to avoid zero-width arrays.
   localparam int unsigned HIST = (PATTERN_LEN > 1) ? PATTERN_LEN - 1 : 1;
   localparam int unsigned SLEN = LANES + HIST;
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN - 1);

   // ---------------------------------------------------------------------------------
   // Symbol stream: position 0 = lane 0 (latest), LANES-1 = earliest lane,
   // LANES+h = history symbol h (h=0 most recent).
   // ---------------------------------------------------------------------------------
   logic [7:0]        hist_data_q [HIST];
   logic [HIST-1:0]   hist_ctl_q;
   logic [FILL_W-1:0] hist_fill_q;
   logic [7:0]        stream_data [SLEN];
   logic [SLEN-1:0]   stream_ctl;
   logic [FILL_W:0]   fill_sum;
   logic [FILL_W-1:0] fill_next;

   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         stream_data[j] = sym_data[8*j +: 8];
         stream_ctl[j]  = sym_is_ctl[j];
      end
      for (int h = 0; h < HIST; h++) begin
         stream_data[LANES+h] = hist_data_q[h];
         stream_ctl[LANES+h]  = hist_ctl_q[h];
      end
   end

   assign fill_sum  = {1'b0, hist_fill_q} + (FILL_W+1)'(LANES);
   assign fill_next = (fill_sum > {1'b0, FILL_MAX}) ? FILL_MAX : fill_sum[FILL_W-1:0];

   // A valid word shifts the whole stream down by LANES; the newest HIST symbols remain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int h = 0; h < HIST; h++) hist_data_q[h] <= '0;
         hist_ctl_q  <= '0;
         hist_fill_q <= '0;
      end else if (!lock_in) begin
         for (int h = 0; h < HIST; h++) hist_data_q[h] <= '0;
         hist_ctl_q  <= '0;
         hist_fill_q <= '0;
      end else if (sym_valid) begin
         for (int h = 0; h < HIST; h++) hist_data_q[h] <= stream_data[h];
         hist_ctl_q  <= stream_ctl[HIST-1:0];
         hist_fill_q <= fill_next;
      end
   end

   // ---------------------------------------------------------------------------------
   // Per-offset pattern compare: offset k ends the pattern at lane k, so pattern
   // symbol i sits at stream position k + PATTERN_LEN-1-i.
   // ---------------------------------------------------------------------------------
   logic [LANES-1:0] pat_hit;

   for (genvar k = 0; k < LANES; k++) begin : g_off
      localparam int NEED = (int'(PATTERN_LEN) > int'(LANES) - k) ?
                            int'(PATTERN_LEN) - (int'(LANES) - k) : 0;

      logic [PATTERN_LEN*8-1:0] win_data;
      logic [PATTERN_LEN-1:0]   win_ctl;
      logic                     win_match;
      logic                     qual;

      for (genvar i = 0; i < PATTERN_LEN; i++) begin : g_sym
         assign win_data[8*i +: 8] = stream_data[k + PATTERN_LEN - 1 - i];
         assign win_ctl[i]         = stream_ctl[k + PATTERN_LEN - 1 - i];
      end

      // Offsets needing history only qualify once enough real symbols are buffered.
      if (NEED == 0) begin : g_nofill
         assign qual = 1'b1;
      end else begin : g_fill
         assign qual = (hist_fill_q >= FILL_W'(NEED));
      end

      pattern_match_window_8b10b #(
         .PATTERN_LEN (PATTERN_LEN)
      ) u_win (
         .win_data (win_data),
         .win_ctl  (win_ctl),
         .cfg_data (cfg_data),
         .cfg_type (cfg_type),
         .cfg_mask (cfg_mask),
         .match    (win_match)
      );

      assign pat_hit[k] = win_match & qual;
   end

   // ---------------------------------------------------------------------------------
   // Stage 1: registered per-offset hit vector.
   // ---------------------------------------------------------------------------------
   logic [LANES-1:0] hit_d, hit_q;

   always_comb begin
      hit_d = '0;
      if (sym_valid && lock_in) begin
         case (cfg_mode)
            TRIG_8B10B_PATTERN: hit_d = pat_hit;
            TRIG_8B10B_DISPERR: hit_d = sym_disp_err;
            TRIG_8B10B_SYMERR:  hit_d = sym_symbol_err;
            default:            hit_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hit_q <= '0;
      else     hit_q <= hit_d;
   end

   // Highest hitting offset is the earliest-in-time pattern end.
   logic [LANE_W-1:0] lane_sel;

   always_comb begin
      lane_sel = '0;
      for (int k = 0; k < LANES; k++) begin
         if (hit_q[k]) lane_sel = LANE_W'(k);
      end
   end

   // ---------------------------------------------------------------------------------
   // Stage 2: arm / holdoff / single-shot FSM.
   // ---------------------------------------------------------------------------------
   trig_state_t              state_q, state_d;
   logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
   logic                     fire;
   logic                     trig_q;
   logic [LANE_W-1:0]        lane_q;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      fire    = 1'b0;
      unique case (state_q)
         DISARMED: begin
            if (arm) state_d = ARMED;
         end
         ARMED: begin
            if (|hit_q) begin
               fire = 1'b1;
               if (cfg_single) begin
                  state_d = DISARMED;
               end else if (cfg_holdoff != '0) begin
                  hold_d  = cfg_holdoff;
                  state_d = HOLDOFF;
               end
            end
         end
         HOLDOFF: begin
            hold_d = hold_q - 1'b1;
            if (hold_q <= HOLDOFF_WIDTH'(1)) begin
               hold_d  = '0;
               state_d = ARMED;
            end
         end
         default: state_d = DISARMED;
      endcase
      // disarm overrides everything, including a same-cycle hit.
      if (disarm) begin
         state_d = DISARMED;
         hold_d  = '0;
         fire    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DISARMED;
         hold_q  <= '0;
         trig_q  <= 1'b0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         trig_q  <= fire;
         if (fire) lane_q <= lane_sel;
      end
   end

   assign trig_out   = trig_q;
   assign match_lane = lane_q;
   assign armed      = (state_q == ARMED);

   // ---------------------------------------------------------------------------------
   // Optional saturating match counter.
   // ---------------------------------------------------------------------------------
`ifdef CDR_TRIG_MATCH_COUNTER_EN
   logic [31:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (match_count_clr) begin
         count_q <= '0;
      end else if (fire && (count_q != '1)) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign match_count = count_q;
`else
   logic unused_count_clr;

   assign unused_count_clr = match_count_clr;
   assign match_count      = '0;
`endif

endmodule

// File: tb/tb_cdr_trigger_8b10b_matcher.sv
// Directed, table-driven bench for cdr_trigger_8b10b_matcher with LANES=4, PATTERN_LEN=4.
// Pattern: BC(K) B5 50 50 (symbol 0 earliest). Each table row is one clock: inputs are
// applied at the falling edge and outputs sampled 1 time unit after the next rising edge,
// so a hit carried by row n shows on trig_out in row n+1.
module tb_cdr_trigger_8b10b_matcher;

   localparam int L  = 4;
   localparam int P  = 4;
   localparam int HW = 16;

   localparam logic [31:0] W_F  = 32'h0000_0000;  // filler
   localparam logic [31:0] W_P  = 32'hBCB5_5050;  // full pattern, lanes 3..0
   localparam logic [31:0] W_A  = 32'h0000_BCB5;  // first half on lanes 1,0
   localparam logic [31:0] W_B  = 32'h5050_0000;  // second half on lanes 3,2
   localparam logic [31:0] W_M  = 32'hBCB5_7750;  // symbol 2 replaced by 0x77

   logic                clk = 1'b0;
   logic                rst;
   logic                sym_valid;
   logic [L*8-1:0]      sym_data;
   logic [L-1:0]        sym_is_ctl;
   logic [L-1:0]        sym_disp_err;
   logic [L-1:0]        sym_symbol_err;
   logic                lock_in;
   logic [1:0]          cfg_mode;
   logic [P*8-1:0]      cfg_data;
   logic [P-1:0]        cfg_type;
   logic [P-1:0]        cfg_mask;
   logic                cfg_single;
   logic [HW-1:0]       cfg_holdoff;
   logic                arm;
   logic                disarm;
   logic                match_count_clr;
   logic                trig_out;
   logic [1:0]          match_lane;
   logic                armed;
   logic [31:0]         match_count;

   always #5 clk = ~clk;

   cdr_trigger_8b10b_matcher #(
      .LANES         (L),
      .PATTERN_LEN   (P),
      .HOLDOFF_WIDTH (HW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sym_valid       (sym_valid),
      .sym_data        (sym_data),
      .sym_is_ctl      (sym_is_ctl),
      .sym_disp_err    (sym_disp_err),
      .sym_symbol_err  (sym_symbol_err),
      .lock_in         (lock_in),
      .cfg_mode        (cfg_mode),
      .cfg_data        (cfg_data),
      .cfg_type        (cfg_type),
      .cfg_mask        (cfg_mask),
      .cfg_single      (cfg_single),
      .cfg_holdoff     (cfg_holdoff),
      .arm             (arm),
      .disarm          (disarm),
      .match_count_clr (match_count_clr),
      .trig_out        (trig_out),
      .match_lane      (match_lane),
      .armed           (armed),
      .match_count     (match_count)
   );

   typedef struct {
      logic        valid;
      logic        lock;
      logic [31:0] data;
      logic [3:0]  ctl;
      logic [3:0]  derr;
      logic [3:0]  serr;
      logic [1:0]  mode;
      logic [3:0]  mask;
      logic        arm;
      logic        disarm;
      logic        exp_trig;
      logic        chk_lane;
      logic [1:0]  exp_lane;
      logic        exp_armed;
   } vec_t;

   int   n_checks = 0;
   int   n_fails  = 0;
   int   exp_cnt  = 0;
   vec_t tbl [30];

   function automatic vec_t mk(input logic v, input logic lk, input logic [31:0] d,
                               input logic [3:0] c, input logic [3:0] de,
                               input logic [3:0] se, input logic [1:0] md,
                               input logic [3:0] mk_, input logic a, input logic da,
                               input logic et, input logic cl, input logic [1:0] el,
                               input logic ea);
      vec_t r;
      r.valid = v;   r.lock = lk;   r.data = d;     r.ctl = c;
      r.derr = de;   r.serr = se;   r.mode = md;    r.mask = mk_;
      r.arm = a;     r.disarm = da; r.exp_trig = et; r.chk_lane = cl;
      r.exp_lane = el; r.exp_armed = ea;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      sym_valid       = v.valid;
      lock_in         = v.lock;
      sym_data        = v.data;
      sym_is_ctl      = v.ctl;
      sym_disp_err    = v.derr;
      sym_symbol_err  = v.serr;
      cfg_mode        = v.mode;
      cfg_mask        = v.mask;
      arm             = v.arm;
      disarm          = v.disarm;
      match_count_clr = 1'b0;
      @(posedge clk);
      #1;
   endtask

   int   pulses;
   int   exp_mc;
   vec_t vp, vf;

   initial begin
      rst = 1'b1;
      sym_valid = 1'b0; sym_data = '0; sym_is_ctl = '0; sym_disp_err = '0;
      sym_symbol_err = '0; lock_in = 1'b1; cfg_mode = 2'd0;
      cfg_data = {8'h50, 8'h50, 8'hB5, 8'hBC};
      cfg_type = 4'b0001;
      cfg_mask = 4'hF;
      cfg_single = 1'b0; cfg_holdoff = '0;
      arm = 1'b0; disarm = 1'b0; match_count_clr = 1'b0;

      //         v  lk data  ctl     derr   serr   md mask   a  da  et cl ln ea
      tbl[0]  = mk(0, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 1, 0, 0, 0, 0, 1);
      tbl[1]  = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[2]  = mk(1, 1, W_P, 4'h8, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[3]  = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 1, 1, 0, 1);
      tbl[4]  = mk(1, 1, W_A, 4'h2, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[5]  = mk(1, 1, W_B, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[6]  = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 1, 1, 2, 1);
      tbl[7]  = mk(1, 1, W_M, 4'h8, 4'h0, 4'h0, 0, 4'hB, 0, 0, 0, 0, 0, 1);
      tbl[8]  = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 1, 1, 0, 1);
      tbl[9]  = mk(1, 1, W_P, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[10] = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[11] = mk(1, 1, W_F, 4'h0, 4'h4, 4'h0, 1, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[12] = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 1, 1, 2, 1);
      tbl[13] = mk(1, 1, W_F, 4'h0, 4'h0, 4'h2, 2, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[14] = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 1, 1, 1, 1);
      tbl[15] = mk(1, 1, W_F, 4'h0, 4'hF, 4'h0, 2, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[16] = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[17] = mk(1, 1, W_F, 4'h0, 4'hF, 4'hF, 3, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[18] = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[19] = mk(0, 0, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[20] = mk(1, 1, W_B, 4'h0, 4'h0, 4'h0, 0, 4'hC, 0, 0, 0, 0, 0, 1);
      tbl[21] = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[22] = mk(1, 1, W_B, 4'h0, 4'h0, 4'h0, 0, 4'hC, 0, 0, 0, 0, 0, 1);
      tbl[23] = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 1, 1, 2, 1);
      tbl[24] = mk(1, 0, W_P, 4'h8, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[25] = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[26] = mk(1, 1, W_A, 4'h2, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[27] = mk(0, 0, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[28] = mk(1, 1, W_B, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);
      tbl[29] = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 1);

      vp = mk(1, 1, W_P, 4'h8, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 0);
      vf = mk(1, 1, W_F, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset trig_out", 32'(trig_out), 0);
      check("reset match_lane", 32'(match_lane), 0);
      check("reset armed", 32'(armed), 0);
      check("reset match_count", match_count, 0);
      @(negedge clk);
      rst = 1'b0;

      // Table: alignment, straddle, mask, K-flag, error modes, lock loss
      for (int i = 0; i < 30; i++) begin
         drive(tbl[i]);
         check($sformatf("row%0d trig_out", i), 32'(trig_out), 32'(tbl[i].exp_trig));
         check($sformatf("row%0d armed", i), 32'(armed), 32'(tbl[i].exp_armed));
         if (tbl[i].chk_lane)
            check($sformatf("row%0d match_lane", i), 32'(match_lane), 32'(tbl[i].exp_lane));
         if (tbl[i].exp_trig) exp_cnt++;
      end

      // Holdoff of 5 with the pattern in every word: pulses every 6 cycles
      cfg_holdoff = 16'd5;
      for (int r = 0; r < 16; r++) begin
         drive(vp);
         check($sformatf("holdoff r%0d trig_out", r), 32'(trig_out), 32'(r % 6 == 1));
         check($sformatf("holdoff r%0d armed", r), 32'(armed), 32'(r % 6 == 0));
      end
      exp_cnt += 3;
      for (int r = 0; r < 4; r++) drive(vf);
      check("holdoff rearmed", 32'(armed), 1);
      check("holdoff no spurious trig", 32'(trig_out), 0);

      // Single-shot: exactly one pulse, then disarmed
      cfg_holdoff = '0;
      cfg_single  = 1'b1;
      pulses = 0;
      for (int r = 0; r < 6; r++) begin
         drive(vp);
         if (trig_out) pulses++;
      end
      exp_cnt += 1;
      check("single pulse count", 32'(pulses), 1);
      check("single armed after", 32'(armed), 0);
      cfg_single = 1'b0;

      // arm + disarm together: disarm wins
      vf.arm = 1'b1; vf.disarm = 1'b1;
      drive(vf);
      check("arm+disarm armed", 32'(armed), 0);
      vf.disarm = 1'b0;
      drive(vf);
      check("arm armed", 32'(armed), 1);
      vf.arm = 1'b0;

      // disarm coincident with a hit: no pulse
      drive(vp);
      vf.disarm = 1'b1;
      drive(vf);
      check("disarm+hit trig_out", 32'(trig_out), 0);
      check("disarm+hit armed", 32'(armed), 0);
      vf.disarm = 1'b0;
      drive(vf);
      check("disarm+hit trig_out later", 32'(trig_out), 0);
      check("match_lane kept", 32'(match_lane), 0);

      // Counter value, then clear
`ifdef CDR_TRIG_MATCH_COUNTER_EN
      exp_mc = exp_cnt;
`else
      exp_mc = 0;
`endif
      check("match_count", match_count, 32'(exp_mc));
      @(negedge clk);
      match_count_clr = 1'b1;
      @(posedge clk);
      #1;
      match_count_clr = 1'b0;
      check("match_count cleared", match_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/cdr_trigger_8b10b_matcher.md
Name: cdr_trigger_8b10b_matcher

Overview:
- Parametrised 8b/10b pattern/error trigger for the CDR trigger path.
- Consumes the per-lane outputs of the 8b/10b decoders: LANES symbols per valid cycle, with data, control flag and error flags.
- Matches a programmable PATTERN_LEN-symbol sequence at any lane alignment, including patterns straddling words. Alternatively triggers on disparity or symbol errors.
- Arm/holdoff/single-shot FSM gates a one-cycle trig_out pulse to the crossbar. The register-file wrapper drives all cfg_* ports.

Parameters:
LANES, 4, symbols delivered per valid cycle (1..8)
PATTERN_LEN, 10, pattern length in symbols (1..16)
HOLDOFF_WIDTH, 16, width of holdoff counter

Ports:
clk  in  1  rx_clk domain clock
rst  in  1  asynchronous active-high reset
sym_valid  in  1  lane inputs valid this cycle
sym_data  in  LANES*8  decoded bytes; lane g at [8g+:8]; lane LANES-1 earliest in time, lane 0 latest
sym_is_ctl  in  LANES  K-symbol flag per lane
sym_disp_err  in  LANES  disparity error per lane
sym_symbol_err  in  LANES  invalid codeword per lane
lock_in  in  1  aligner locked (all lanes)
cfg_mode  in  2  0=pattern, 1=disparity error, 2=symbol error, 3=reserved (never fires)
cfg_data  in  PATTERN_LEN*8  pattern bytes; symbol 0 (earliest) at [7:0]
cfg_type  in  PATTERN_LEN  1=control expected
cfg_mask  in  PATTERN_LEN  1=symbol checked
cfg_single  in  1  1=single-shot
cfg_holdoff  in  HOLDOFF_WIDTH  rearm delay in clk cycles
arm  in  1  pulse: arm
disarm  in  1  pulse: disarm
match_count_clr  in  1  pulse: clear match counter
trig_out  out  1  one-cycle trigger pulse
match_lane  out  $clog2(LANES) (min 1)  lane of last pattern symbol for last trigger
armed  out  1  FSM in ARMED
match_count  out  32  saturating count of qualified hits

Behaviour:
- Reset: trig_out=0, match_lane=0, armed=0, match_count=0, FSM=DISARMED, history=0, hist_fill=0, holdoff counter=0.
- Async reset assertion clears all state immediately; release is synchronous to clk.
- History: shift register of the previous PATTERN_LEN-1 symbols (data, ctl). On sym_valid, shift in all LANES symbols.
- hist_fill counts buffered symbols, +LANES per valid, saturating at PATTERN_LEN-1.
- lock_in low: history and hist_fill cleared, no hits generated.
- Offset k (0..LANES-1) = pattern ends at lane k.
  - Needs PATTERN_LEN-(LANES-k) history symbols, 0 if negative.
  - Offset qualifies only if hist_fill meets that requirement.
  - A symbol matches if cfg_mask bit is 0, or (data==cfg_data byte AND is_ctl==cfg_type bit).
- Stage 1 (registered): per-offset hit vector. Mode 0 uses the pattern compare. Modes 1/2 use OR of the corresponding per-lane error flags, offset = erroring lane.
- Stage 2: FSM evaluates hits.
- Several offsets hit in the same cycle: one trigger, match_lane = highest hitting index (earliest in time).
- Latency: trig_out asserts exactly 2 clk after the sym_valid cycle carrying the last pattern symbol.
- FSM states:
  - DISARMED: arm -> ARMED.
  - ARMED: hit -> pulse trig_out, latch match_lane. Then cfg_single=1 -> DISARMED; else cfg_holdoff=0 -> stay ARMED; else load counter and go HOLDOFF.
  - HOLDOFF: decrement each clk; hits ignored; counter reaching 1 -> ARMED on next edge.
- disarm forces DISARMED from any state and wins over arm and over a same-cycle hit (no pulse).
- arm while ARMED or HOLDOFF: ignored.
- Config changes take effect on the next sym_valid compare; no shadowing.
- match_count: increments on every ARMED-state trigger, saturates at 0xFFFFFFFF. match_count_clr wins over a simultaneous increment.

Optional Feature:
- CDR_TRIG_MATCH_COUNTER_EN defined: match_count behaves as above.
- Undefined: counter logic is not built and match_count is tied to 0. Ports are unchanged.

Decomposition:
- Package cdrtrig_pkg holds:
  - trig_mode_t enum (TRIG_8B10B_PATTERN, TRIG_8B10B_DISPERR, TRIG_8B10B_SYMERR);
  - trig_state_t (DISARMED, ARMED, HOLDOFF);
  - constant MAX_PATTERN_LEN=16.
- One sub-module, pattern_match_window_8b10b: compares one offset's PATTERN_LEN-symbol window against cfg_data/type/mask. It is instantiated LANES times in a generate loop.

Test Plan (LANES=4, PATTERN_LEN=4; pattern BC(K), B5, 50, 50; mask=4'hF):
1. Armed; words (lane3..0) {BC/K,B5,50,50} after 1 filler word -> trig_out pulses 2 cycles after that word, match_lane=0.
2. Pattern straddles words: lanes 1,0 = BC/K,B5 then lanes 3,2 = 50,50 -> trig_out on the 2nd word +2, match_lane=2.
3. Mask=4'b1011 (symbol 2 ignored), symbol 2 = 0x77 -> trigger. Mask 4'hF, symbol 0 = BC as data -> no trigger.
4. cfg_holdoff=5, pattern every word -> pulses spaced by holdoff plus rearm cycle. cfg_single=1 -> exactly one pulse, then armed=0.
5. arm and disarm in the same cycle -> armed=0. disarm coincident with hit -> no pulse.
6. Mode 1, disparity error on lane 2 -> trig_out +2, match_lane=2. lock_in dropped mid-pattern then restored -> no trigger until hist_fill refills.
